flag_ctx_stack: RTL and testbench

- Parametrised condition-flag context store for the EX stage.
- Holds the live flag register written by compare operations, plus a DEPTH-entry LIFO of saved flag contexts.
  - A context is pushed on interrupt entry and popped on return, so nested interrupts keep the interrupted code's flags intact.
- Feeds the registered flags to branch logic.
- Raises sticky overflow and underflow errors to the control/debug path.

---
 rtl/flag_ctx_stack_pkg.sv | 31 +++
 rtl/flag_ctx_stack_lifo.sv | 63 ++++++
 rtl/flag_ctx_stack.sv | 114 +++++++++++
 tb/tb_flag_ctx_stack.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/flag_ctx_stack_pkg.sv
// Shared cpu constants for condition flags and the interrupt context stack.
package flag_ctx_stack_pkg;

    localparam int FLAG_W_DEF = 2;
    localparam int DEPTH_DEF  = 4;

    // Flag bit positions inside one context.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;

    // Stack-related event seen in one cycle.
    typedef enum logic [1:0] {
        EV_NONE    = 2'b00,
        EV_SAVE    = 2'b01,
        EV_RESTORE = 2'b10,
        EV_BOTH    = 2'b11
    } ctx_ev_e;

    // Classify the save/restore request pair.
    function automatic ctx_ev_e decode_ev(input logic save, input logic restore);
        ctx_ev_e ev;
        case ({restore, save})
            2'b01:   ev = EV_SAVE;
            2'b10:   ev = EV_RESTORE;
            2'b11:   ev = EV_BOTH;
            default: ev = EV_NONE;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/flag_ctx_stack_lifo.sv
// Saturating LIFO of flag contexts; index 0 holds the oldest entry.
module flag_lifo
    import flag_ctx_stack_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] push_data,
    output logic [FLAG_W-1:0] top_data,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    logic [FLAG_W-1:0] stack_r [DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic [FLAG_W-1:0] top_s;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (sp_r == SP_W'(DEPTH));
    assign empty_s = (sp_r == {SP_W{1'b0}});

    // Storage write and stack pointer update; a push and pop never coincide here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {SP_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {FLAG_W{1'b0}};
            end
        end else if (push && !full_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp_r == SP_W'(i)) begin
                    stack_r[i] <= push_data;
                end
            end
            sp_r <= sp_r + SP_W'(1);
        end else if (pop && !empty_s) begin
            sp_r <= sp_r - SP_W'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

    // Top-of-stack read; popped entries stay in place but are hidden by sp.
    always_comb begin
        top_s = {FLAG_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (sp_r == SP_W'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    assign top_data = top_s;
    assign sp       = sp_r;
    assign full     = full_s;
    assign empty    = empty_s;

endmodule

// File: rtl/flag_ctx_stack.sv
// Live condition-flag register with a saved-context stack for nested interrupts.
module flag_ctx_stack
    import flag_ctx_stack_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmp,
    input  logic [FLAG_W-1:0]            flags_in,
    input  logic                         save,
    input  logic                         restore,
    input  logic                         err_clr,
    output logic [FLAG_W-1:0]            flags_out,
    output logic [FLAG_W-1:0]            top_flags,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [FLAG_W-1:0] cur_r;
    logic [FLAG_W-1:0] cur_nxt_s;
    logic              ovf_r;
    logic              unf_r;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              push_s;
    logic              pop_s;
    logic [FLAG_W-1:0] top_s;
    logic [SP_W-1:0]   sp_s;
    logic              full_s;
    logic              empty_s;
    ctx_ev_e           ev_s;

    flag_lifo #(
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH),
        .SP_W   (SP_W)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (cur_r),
        .top_data  (top_s),
        .sp        (sp_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign ev_s = decode_ev(save, restore);

    // Resolve this cycle's event into stack ops, next live flags and error sets.
    always_comb begin
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        cur_nxt_s = cmp ? flags_in : cur_r;
        case (ev_s)
            EV_SAVE: begin
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            EV_RESTORE: begin
                // Restore overrides any compare in the same cycle.
                if (empty_s) begin
                    unf_set_s = 1'b1;
                    cur_nxt_s = cur_r;
                end else begin
                    pop_s     = 1'b1;
                    cur_nxt_s = top_s;
                end
            end
            EV_BOTH: begin
                // Entry and return cancel out; only the compare takes effect.
                push_s = 1'b0;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Live flag register and sticky errors; a new error wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r <= {FLAG_W{1'b0}};
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            cur_r <= cur_nxt_s;
            ovf_r <= ovf_set_s | (ovf_r & ~err_clr);
            unf_r <= unf_set_s | (unf_r & ~err_clr);
        end
    end

    assign flags_out = cur_r;
    assign top_flags = top_s;
    assign depth     = sp_s;
    assign full      = full_s;
    assign empty     = empty_s;
    assign ovf_err   = ovf_r;
    assign unf_err   = unf_r;

endmodule

// File: tb/tb_flag_ctx_stack.sv
// Scoreboard bench for flag_ctx_stack with DEPTH=4, FLAG_W=2.
module tb_flag_ctx_stack;

    typedef struct packed {
        logic [1:0] fo;
        logic [1:0] top;
        logic [2:0] d;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cmp;
    logic [1:0] flags_in;
    logic       save;
    logic       restore;
    logic       err_clr;
    logic [1:0] flags_out;
    logic [1:0] top_flags;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;

    logic       issue;
    exp_t       exp_q [$];
    string      name_q [$];
    int         n_vec;
    int         n_bad;

    flag_ctx_stack #(.FLAG_W(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp       (cmp),
        .flags_in  (flags_in),
        .save      (save),
        .restore   (restore),
        .err_clr   (err_clr),
        .flags_out (flags_out),
        .top_flags (top_flags),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] fo, input logic [1:0] top, input logic [2:0] d,
                                input logic fu, input logic em, input logic ov, input logic un);
        exp_t e;
        e.fo = fo; e.top = top; e.d = d; e.full = fu; e.empty = em; e.ovf = ov; e.unf = un;
        return e;
    endfunction

    function automatic exp_t actual();
        return {flags_out, top_flags, depth, full, empty, ovf_err, unf_err};
    endfunction

    task automatic chk(input string nm, input exp_t e);
        exp_t a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got fo=%b top=%b d=%0d full=%b empty=%b ovf=%b unf=%b, want fo=%b top=%b d=%0d full=%b empty=%b ovf=%b unf=%b",
                     nm, a.fo, a.top, a.d, a.full, a.empty, a.ovf, a.unf,
                     e.fo, e.top, e.d, e.full, e.empty, e.ovf, e.unf);
        end
    endtask

    // Drive one cycle of stimulus and queue its expected post-edge state.
    task automatic vec(input string nm, input logic c, input logic [1:0] fi, input logic sv,
                       input logic rs, input logic cl, input exp_t e);
        @(negedge clk);
        cmp = c; flags_in = fi; save = sv; restore = rs; err_clr = cl;
        issue = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(negedge clk);
        cmp = 1'b0; flags_in = 2'b00; save = 1'b0; restore = 1'b0; err_clr = 1'b0;
        issue = 1'b0;
    endtask

    // Monitor: after each edge that sampled a vector, pop and compare.
    always @(posedge clk) begin
        if (issue) begin
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard_empty: got no expectation, want one queued");
            end else begin
                chk(name_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    initial begin
        n_vec = 0; n_bad = 0; issue = 1'b0;
        rst_n = 1'b0; cmp = 1'b0; flags_in = 2'b00; save = 1'b0; restore = 1'b0; err_clr = 1'b0;
        #12;
        chk("reset_initial", mk(2'b00, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Three saves to build state, then reset mid-run.
        vec("pre_save1", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, mk(2'b11, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("pre_save2", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b11, 2'b11, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("pre_save3", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b11, 2'b11, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_midrun", mk(2'b00, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Compare latency and save with simultaneous compare.
        vec("cmp01", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vec("save_cmp10", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, mk(2'b10, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("restore_back", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Nested contexts.
        vec("n_cmp01", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vec("n_save1", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b01, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("n_cmp10", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, mk(2'b10, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("n_save2", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b10, 2'b10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("n_cmp11", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, mk(2'b11, 2'b10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("n_rest1", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b10, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("n_rest2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Fill to full, then overflow.
        vec("o_save1", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b01, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("o_save2", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, mk(2'b10, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("o_save3", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b10, 2'b10, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("o_save4", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, mk(2'b10, 2'b10, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        vec("o_save5", 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, mk(2'b11, 2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0));
        vec("o_hold",  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, mk(2'b11, 2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0));
        vec("o_clr",   1'b0, 2'b00, 1'b0, 1'b0, 1'b1, mk(2'b11, 2'b10, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));

        // Drain to depth 2, then simultaneous save/restore.
        vec("d_rest4", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b10, 2'b10, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("d_rest3", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b10, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("s_both_cmp00", 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, mk(2'b00, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("s_rest_cmp11", 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        vec("d_rest1", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Underflow and sticky clear behaviour.
        vec("u_rest_cmp10", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        vec("u_clr",        1'b0, 2'b00, 1'b0, 1'b0, 1'b1, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vec("u_clr_rest",   1'b0, 2'b00, 1'b0, 1'b1, 1'b1, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        vec("u_clr2",       1'b0, 2'b00, 1'b0, 1'b0, 1'b1, mk(2'b01, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        vec("both_empty",   1'b1, 2'b10, 1'b1, 1'b1, 1'b0, mk(2'b10, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
